// File: rtl/chunk_serial_adder_if.sv
// Operand/result handshake bundle for chunk_serial_adder.
// The sub_i signal exists only when CHUNK_ADDER_SUB_EN is defined.
interface chunk_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cy_i;
`ifdef CHUNK_ADDER_SUB_EN
  logic             sub_i;
`endif
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] y_o;
  logic             cy_o;

  modport master (
`ifdef CHUNK_ADDER_SUB_EN
    output sub_i,
`endif
    output in_valid_i, a_i, b_i, cy_i, out_ready_i,
    input  in_ready_o, out_valid_o, y_o, cy_o
  );

  modport slave (
`ifdef CHUNK_ADDER_SUB_EN
    input  sub_i,
`endif
    input  in_valid_i, a_i, b_i, cy_i, out_ready_i,
    output in_ready_o, out_valid_o, y_o, cy_o
  );
endinterface

// File: rtl/chunk_serial_adder.sv
// Serial adder: WIDTH-bit a + b + cy computed CHUNK bits per clock, valid/ready on both sides.
// Optional feature macro CHUNK_ADDER_SUB_EN adds sub_i (a + ~b + cy).
module chunk_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  chunk_serial_adder_if.slave bus
);
  localparam int unsigned NCH   = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int unsigned CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SUM_W = CHUNK + 1;

  if (CHUNK < 1 || WIDTH < 1 || (WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0) begin : g_bad_params
    $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, acc_d;
  logic [WIDTH-1:0]   b_in_c;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SUM_W-1:0]   sum_c;
  logic               last_c;
  logic               accept_c, load_c;
  logic               in_ready_d, out_valid_d;

  // One chunk of the carry chain and the accumulator shift-in
  always_comb begin
    sum_c  = SUM_W'(a_q[CHUNK-1:0]) + SUM_W'(b_q[CHUNK-1:0]) + SUM_W'(carry_q);
    acc_d  = (acc_q >> CHUNK) | (WIDTH'(sum_c[CHUNK-1:0]) << (WIDTH - CHUNK));
    last_c = (cnt_q == CNT_W'(NCH - 1));
`ifdef CHUNK_ADDER_SUB_EN
    b_in_c = bus.sub_i ? ~bus.b_i : bus.b_i;
`else
    b_in_c = bus.b_i;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid_i) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they can be registered
  always_comb begin
    accept_c    = 1'b0;
    load_c      = 1'b0;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    accept_c    = (state_q == IDLE) && bus.in_valid_i;
    load_c      = (state_q == RUN) && last_c;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q             <= '0;
      b_q             <= '0;
      acc_q           <= '0;
      carry_q         <= 1'b0;
      cnt_q           <= '0;
      bus.y_o         <= '0;
      bus.cy_o        <= 1'b0;
      bus.in_ready_o  <= 1'b1;
      bus.out_valid_o <= 1'b0;
    end else begin
      bus.in_ready_o  <= in_ready_d;
      bus.out_valid_o <= out_valid_d;
      if (accept_c) begin
        a_q     <= bus.a_i;
        b_q     <= b_in_c;
        acc_q   <= '0;
        carry_q <= bus.cy_i;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        a_q     <= a_q >> CHUNK;
        b_q     <= b_q >> CHUNK;
        acc_q   <= acc_d;
        carry_q <= sum_c[CHUNK];
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (load_c) begin
        bus.y_o  <= acc_d;
        bus.cy_o <= sum_c[CHUNK];
      end
    end
  end
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench: 8/4 table vectors, back-pressure, mid-op reset, optional subtract,
// and 32-bit builds with CHUNK=32 and CHUNK=8.
module tb_chunk_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chunk_serial_adder_if #(.WIDTH(8))  bus8 ();
  chunk_serial_adder_if #(.WIDTH(32)) bus32a ();
  chunk_serial_adder_if #(.WIDTH(32)) bus32b ();

  chunk_serial_adder #(.WIDTH(8),  .CHUNK(4))  u8  (.clk_i(clk), .rst_i(rst), .bus(bus8));
  chunk_serial_adder #(.WIDTH(32), .CHUNK(32)) u32a(.clk_i(clk), .rst_i(rst), .bus(bus32a));
  chunk_serial_adder #(.WIDTH(32), .CHUNK(8))  u32b(.clk_i(clk), .rst_i(rst), .bus(bus32b));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cy;
    logic [7:0] y;
    logic       ycy;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic        cy;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;
`ifdef CHUNK_ADDER_SUB_EN
  logic sub_sel = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input string name, input logic [31:0] y, input logic cy);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, " y"}, y, e.y);
      chk({name, " cy"}, 32'(cy), 32'(e.cy));
    end
  endtask

  // Full 8-bit transaction with latency and handshake checks
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cy,
                      input logic [7:0] ey, input logic ecy, input string name);
    int lat;
    lat = 0;
    while (!bus8.in_ready_o && lat < 20) begin tick(); lat++; end
    chk({name, " in_ready_idle"}, 32'(bus8.in_ready_o), 32'd1);
    bus8.in_valid_i = 1'b1;
    bus8.a_i = a;
    bus8.b_i = b;
    bus8.cy_i = cy;
`ifdef CHUNK_ADDER_SUB_EN
    bus8.sub_i = sub_sel;
`endif
    sb.push_back('{y: 32'(ey), cy: ecy});
    tick();
    bus8.in_valid_i = 1'b0;
    chk({name, " in_ready_run"}, 32'(bus8.in_ready_o), 32'd0);
    lat = 0;
    do begin tick(); lat++; end while (!bus8.out_valid_o && lat < 20);
    chk({name, " latency"}, 32'(lat), 32'd2);
    chk({name, " in_ready_done"}, 32'(bus8.in_ready_o), 32'd0);
    pop_cmp(name, 32'(bus8.y_o), bus8.cy_o);
    bus8.out_ready_i = 1'b1;
    tick();
    bus8.out_ready_i = 1'b0;
    chk({name, " out_valid_drop"}, 32'(bus8.out_valid_o), 32'd0);
  endtask

  // Drives both 32-bit builds together and checks their distinct latencies
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic cy,
                      input logic [31:0] ey, input logic ecy, input string name);
    int lat, lat_a, lat_b;
    bit done_a, done_b;
    bus32a.in_valid_i = 1'b1; bus32a.a_i = a; bus32a.b_i = b; bus32a.cy_i = cy;
    bus32b.in_valid_i = 1'b1; bus32b.a_i = a; bus32b.b_i = b; bus32b.cy_i = cy;
    sb.push_back('{y: ey, cy: ecy});
    sb.push_back('{y: ey, cy: ecy});
    tick();
    bus32a.in_valid_i = 1'b0;
    bus32b.in_valid_i = 1'b0;
    lat = 0; lat_a = -1; lat_b = -1; done_a = 0; done_b = 0;
    while (!(done_a && done_b) && lat < 20) begin
      tick();
      lat++;
      if (!done_a && bus32a.out_valid_o) begin lat_a = lat; done_a = 1; end
      if (!done_b && bus32b.out_valid_o) begin lat_b = lat; done_b = 1; end
    end
    chk({name, " c32 latency"}, 32'(lat_a), 32'd1);
    chk({name, " c8 latency"}, 32'(lat_b), 32'd4);
    pop_cmp({name, " c32"}, bus32a.y_o, bus32a.cy_o);
    pop_cmp({name, " c8"}, bus32b.y_o, bus32b.cy_o);
    bus32a.out_ready_i = 1'b1;
    bus32b.out_ready_i = 1'b1;
    tick();
    bus32a.out_ready_i = 1'b0;
    bus32b.out_ready_i = 1'b0;
    chk({name, " c32 released"}, 32'(bus32a.out_valid_o), 32'd0);
    chk({name, " c8 released"}, 32'(bus32b.out_valid_o), 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{a: 8'd0,    b: 8'd0,    cy: 1'b0, y: 8'd0,    ycy: 1'b0};
    vecs[1] = '{a: 8'd255,  b: 8'd255,  cy: 1'b1, y: 8'd255,  ycy: 1'b1};
    vecs[2] = '{a: 8'd100,  b: 8'd155,  cy: 1'b1, y: 8'd0,    ycy: 1'b1};
    vecs[3] = '{a: 8'd255,  b: 8'd0,    cy: 1'b1, y: 8'd0,    ycy: 1'b1};
    vecs[4] = '{a: 8'h12,   b: 8'h34,   cy: 1'b0, y: 8'h46,   ycy: 1'b0};
    vecs[5] = '{a: 8'h0F,   b: 8'h01,   cy: 1'b0, y: 8'h10,   ycy: 1'b0};
    vecs[6] = '{a: 8'd200,  b: 8'd100,  cy: 1'b0, y: 8'd44,   ycy: 1'b1};

    bus8.in_valid_i = 0; bus8.a_i = 0; bus8.b_i = 0; bus8.cy_i = 0; bus8.out_ready_i = 0;
    bus32a.in_valid_i = 0; bus32a.a_i = 0; bus32a.b_i = 0; bus32a.cy_i = 0; bus32a.out_ready_i = 0;
    bus32b.in_valid_i = 0; bus32b.a_i = 0; bus32b.b_i = 0; bus32b.cy_i = 0; bus32b.out_ready_i = 0;
`ifdef CHUNK_ADDER_SUB_EN
    bus8.sub_i = 0; bus32a.sub_i = 0; bus32b.sub_i = 0;
`endif
    rst = 1'b1;
    tick(); tick();
    chk("reset in_ready", 32'(bus8.in_ready_o), 32'd1);
    chk("reset out_valid", 32'(bus8.out_valid_o), 32'd0);
    chk("reset y", 32'(bus8.y_o), 32'd0);
    chk("reset cy", 32'(bus8.cy_o), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].cy, vecs[i].y, vecs[i].ycy, $sformatf("vec%0d", i));

    // Back-pressure: result held while out_ready_i is low, in_valid_i ignored
    bus8.in_valid_i = 1'b1; bus8.a_i = 8'd1; bus8.b_i = 8'd1; bus8.cy_i = 1'b1;
    sb.push_back('{y: 32'd3, cy: 1'b0});
    tick();
    bus8.in_valid_i = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!bus8.out_valid_o && lat < 20);
    chk("bp latency", 32'(lat), 32'd2);
    pop_cmp("bp", 32'(bus8.y_o), bus8.cy_o);
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid_i = (i % 2 == 0);
      bus8.a_i = 8'(i * 17 + 5);
      tick();
      chk($sformatf("bp hold%0d out_valid", i), 32'(bus8.out_valid_o), 32'd1);
      chk($sformatf("bp hold%0d y", i), 32'(bus8.y_o), 32'd3);
      chk($sformatf("bp hold%0d cy", i), 32'(bus8.cy_o), 32'd0);
      chk($sformatf("bp hold%0d in_ready", i), 32'(bus8.in_ready_o), 32'd0);
    end
    bus8.in_valid_i = 1'b0;
    bus8.out_ready_i = 1'b1;
    tick();
    bus8.out_ready_i = 1'b0;
    chk("bp release out_valid", 32'(bus8.out_valid_o), 32'd0);
    chk("bp release in_ready", 32'(bus8.in_ready_o), 32'd1);
    tick();
    chk("bp no phantom op", 32'(bus8.in_ready_o), 32'd1);
    chk("bp y held between ops", 32'(bus8.y_o), 32'd3);

    // Reset during the second RUN cycle aborts the op
    bus8.in_valid_i = 1'b1; bus8.a_i = 8'd200; bus8.b_i = 8'd100; bus8.cy_i = 1'b0;
    tick();
    bus8.in_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort out_valid", 32'(bus8.out_valid_o), 32'd0);
    chk("abort in_ready", 32'(bus8.in_ready_o), 32'd1);
    chk("abort y", 32'(bus8.y_o), 32'd0);
    chk("abort cy", 32'(bus8.cy_o), 32'd0);
    tick();
    chk("abort stays idle", 32'(bus8.out_valid_o), 32'd0);
    run8(8'd0, 8'd255, 1'b0, 8'd255, 1'b0, "post_abort");

`ifdef CHUNK_ADDER_SUB_EN
    sub_sel = 1'b1;
    run8(8'd5, 8'd3, 1'b1, 8'd2, 1'b1, "sub 5-3");
    run8(8'd3, 8'd5, 1'b1, 8'd254, 1'b0, "sub 3-5");
    run8(8'd7, 8'd7, 1'b1, 8'd0, 1'b1, "sub 7-7");
    sub_sel = 1'b0;
    run8(8'd5, 8'd3, 1'b1, 8'd9, 1'b0, "sub off");
`endif

    op32(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, "w32 wrap");
    op32(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 32'h2222_2221, 1'b0, "w32 mix");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
